// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int NUM_PORTS       = 2;
  localparam int DEF_WAIT_CYCLES = 2;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Requester and SRAM-side signal bundle of mem_arbiter; slave modport is the arbiter view.
interface mem_arb_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic [1:0]        Req;
  logic [1:0]        We;
  logic [ADDR_W-1:0] Addr0;
  logic [ADDR_W-1:0] Addr1;
  logic [DATA_W-1:0] Wdata0;
  logic [DATA_W-1:0] Wdata1;
  logic [1:0]        Done;
  logic [DATA_W-1:0] Rdata;
  logic [ADDR_W-1:0] Mem_addr;
  logic [DATA_W-1:0] Mem_wdata;
  logic              Mem_data_oe;
  logic [DATA_W-1:0] Mem_rdata;
  logic              CE_n;
  logic              OE_n;
  logic              WE_n;

  modport slave (
    input  Req, We, Addr0, Addr1, Wdata0, Wdata1, Mem_rdata,
    output Done, Rdata, Mem_addr, Mem_wdata, Mem_data_oe, CE_n, OE_n, WE_n
  );

  modport master (
    output Req, We, Addr0, Addr1, Wdata0, Wdata1, Mem_rdata,
    input  Done, Rdata, Mem_addr, Mem_wdata, Mem_data_oe, CE_n, OE_n, WE_n
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select. With MEM_ARB_RR_EN the last-grant pointer breaks ties,
// otherwise port 0 has fixed priority and the pointer is ignored.
module mem_arb_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  // Round-robin: a contested grant goes to the port not served last.
  always_comb begin
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end
`else
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: port 1 only wins when port 0 is silent.
  always_comb begin
    grant = 1'b0;
    if (req[0]) begin
      grant = 1'b0;
    end else begin
      grant = req[1];
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for a shared asynchronous SRAM.
// Build option: MEM_ARB_RR_EN selects round-robin instead of fixed port-0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic     Clk,
  input  logic     Reset_n,
  mem_arb_if.slave bus
);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_r, state_s;
  logic [3:0]        cnt_r;
  logic              win_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rdata_r;
  logic              ce_n_r, oe_n_r, we_n_r, doe_r;
  logic [1:0]        done_r;
  logic              ce_n_s, oe_n_s, we_n_s, doe_s;
  logic [1:0]        done_s;
  logic              pick_s, last_s, start_s, we_next_s;

  assign start_s   = (state_r == IDLE) && (|bus.Req);
  assign we_next_s = start_s ? bus.We[pick_s] : we_r;

`ifdef MEM_ARB_RR_EN
  logic last_r;

  // Remember the port most recently granted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_r <= 1'b0;
    end else if (start_s) begin
      last_r <= pick_s;
    end
  end
  assign last_s = last_r;
`else
  assign last_s = 1'b0;
`endif

  mem_arb_pick u_pick (
    .req   (bus.Req),
    .last  (last_s),
    .grant (pick_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (|bus.Req) state_s = ACCESS; else state_s = IDLE;
      ACCESS:  if (cnt_r == 4'd0) state_s = DONE; else state_s = ACCESS;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Strobe/done values for the upcoming state; registered below so pins never glitch.
  always_comb begin
    ce_n_s = 1'b1;
    oe_n_s = 1'b1;
    we_n_s = 1'b1;
    doe_s  = 1'b0;
    done_s = 2'b00;
    case (state_s)
      ACCESS: begin
        ce_n_s = 1'b0;
        if (we_next_s) begin
          we_n_s = 1'b0;
          doe_s  = 1'b1;
        end else begin
          oe_n_s = 1'b0;
        end
      end
      DONE:    done_s = port_onehot(win_r);
      default: done_s = 2'b00;
    endcase
  end

  // Output registers; read data is sampled at the end of the last strobe cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      doe_r   <= 1'b0;
      done_r  <= 2'b00;
      rdata_r <= '0;
    end else begin
      ce_n_r <= ce_n_s;
      oe_n_r <= oe_n_s;
      we_n_r <= we_n_s;
      doe_r  <= doe_s;
      done_r <= done_s;
      if ((state_r == ACCESS) && (cnt_r == 4'd0) && !we_r) begin
        rdata_r <= bus.Mem_rdata;
      end
    end
  end

  // Latch the winner's request at grant time and run the wait counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      win_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
      cnt_r   <= 4'd0;
    end else if (start_s) begin
      win_r   <= pick_s;
      we_r    <= bus.We[pick_s];
      addr_r  <= pick_s ? bus.Addr1 : bus.Addr0;
      wdata_r <= pick_s ? bus.Wdata1 : bus.Wdata0;
      cnt_r   <= CNT_LOAD;
    end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign bus.CE_n        = ce_n_r;
  assign bus.OE_n        = oe_n_r;
  assign bus.WE_n        = we_n_r;
  assign bus.Mem_data_oe = doe_r;
  assign bus.Done        = done_r;
  assign bus.Rdata       = rdata_r;
  assign bus.Mem_addr    = addr_r;
  assign bus.Mem_wdata   = wdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural SRAM; honours MEM_ARB_RR_EN.
module tb_mem_arbiter;
  localparam int WC = 2;

  typedef struct {
    logic [1:0]  done;
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic [15:0] sram   [0:255];
  logic [15:0] shadow [0:255];
  logic last_grant = 1'b0;

  mem_arb_if #(.ADDR_W(20), .DATA_W(16)) bus ();

  mem_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(WC)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  assign bus.Mem_rdata = sram[bus.Mem_addr[7:0]];

  always @(posedge Clk) begin
    if (!bus.CE_n && !bus.WE_n && bus.Mem_data_oe) sram[bus.Mem_addr[7:0]] <= bus.Mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic pick_model(input logic [1:0] req);
`ifdef MEM_ARB_RR_EN
    if (req == 2'b11) return ~last_grant;
    return req[1] & ~req[0];
`else
    return ~req[0];
`endif
  endfunction

  task automatic push_exp(input logic p, input logic w, input logic [7:0] a);
    exp_t e;
    e.done = (p ? 2'b10 : 2'b01);
    e.rd   = ~w;
    e.data = shadow[a];
    sb.push_back(e);
    last_grant = p;
  endtask

  // Scoreboard monitor: every Done pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (bus.Done != 2'b00) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(bus.Done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_port", 32'(bus.Done), 32'(e.done));
        if (e.rd) chk("rdata", 32'(bus.Rdata), 32'(e.data));
      end
    end
  end

  task automatic run_access(input logic p, input logic w, input logic [19:0] a,
                            input logic [15:0] d, input bit drop_early);
    int n = 0;
    int ce_lo = 0, oe_lo = 0, we_lo = 0, doe_hi = 0;
    bit got = 0;
    @(negedge Clk);
    bus.Req[p] = 1'b1;
    bus.We[p]  = w;
    if (p) begin bus.Addr1 = a; bus.Wdata1 = d; end
    else   begin bus.Addr0 = a; bus.Wdata0 = d; end
    push_exp(p, w, a[7:0]);
    if (w) shadow[a[7:0]] = d;
    while (!got && n < 40) begin
      @(negedge Clk);
      n++;
      if (drop_early && n == 1) bus.Req[p] = 1'b0;
      if (!bus.CE_n) ce_lo++;
      if (!bus.OE_n) oe_lo++;
      if (!bus.WE_n) we_lo++;
      if (bus.Mem_data_oe) doe_hi++;
      if (bus.Done != 2'b00) begin
        got = 1;
        bus.Req[p] = 1'b0;
        chk("mem_addr", 32'(bus.Mem_addr), 32'(a));
      end
    end
    chk("latency", 32'(n), 32'(WC + 1));
    chk("ce_len", 32'(ce_lo), 32'(WC));
    chk("oe_len", 32'(oe_lo), w ? 32'd0 : 32'(WC));
    chk("we_len", 32'(we_lo), w ? 32'(WC) : 32'd0);
    chk("doe_len", 32'(doe_hi), w ? 32'(WC) : 32'd0);
  endtask

  initial begin
    int got, n;
    for (int i = 0; i < 256; i++) begin
      sram[i]   = 16'h0000;
      shadow[i] = 16'h0000;
    end
    sram[8'h10]   = 16'h1234;
    shadow[8'h10] = 16'h1234;
    bus.Req = 2'b00; bus.We = 2'b00;
    bus.Addr0 = 20'h0; bus.Addr1 = 20'h0;
    bus.Wdata0 = 16'h0; bus.Wdata1 = 16'h0;

    repeat (2) @(negedge Clk);
    chk("rst_ce", 32'(bus.CE_n), 32'd1);
    chk("rst_oe", 32'(bus.OE_n), 32'd1);
    chk("rst_we", 32'(bus.WE_n), 32'd1);
    chk("rst_doe", 32'(bus.Mem_data_oe), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_rdata", 32'(bus.Rdata), 32'd0);
    chk("rst_addr", 32'(bus.Mem_addr), 32'd0);
    chk("rst_wdata", 32'(bus.Mem_wdata), 32'd0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    run_access(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0);
    run_access(1'b1, 1'b1, 20'h00020, 16'hBEEF, 1'b0);
    chk("sram_write", 32'(sram[8'h20]), 32'h0000BEEF);
    run_access(1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0);

    // Reset during the first ACCESS cycle aborts the access silently.
    @(negedge Clk);
    bus.Req[0] = 1'b1; bus.We[0] = 1'b0; bus.Addr0 = 20'h00030;
    @(negedge Clk);
    chk("pre_rst_ce", 32'(bus.CE_n), 32'd0);
    #1 Reset_n = 1'b0;
    #1;
    chk("abort_ce", 32'(bus.CE_n), 32'd1);
    chk("abort_oe", 32'(bus.OE_n), 32'd1);
    chk("abort_done", 32'(bus.Done), 32'd0);
    chk("abort_rdata", 32'(bus.Rdata), 32'd0);
    bus.Req = 2'b00;
    last_grant = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("post_rst_idle", 32'({bus.CE_n, bus.OE_n, bus.WE_n}), 32'd7);
    end

    run_access(1'b1, 1'b0, 20'h00020, 16'h0000, 1'b1);
    repeat (8) @(negedge Clk);

    // Both ports requesting continuously for four grants.
    @(negedge Clk);
    bus.We = 2'b00; bus.Addr0 = 20'h00010; bus.Addr1 = 20'h00020;
    bus.Req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = pick_model(2'b11);
      push_exp(g, 1'b0, g ? 8'h20 : 8'h10);
    end
    got = 0;
    n = 0;
    while (got < 4 && n < 100) begin
      @(negedge Clk);
      n++;
      if (bus.Done != 2'b00) got++;
    end
    bus.Req = 2'b00;
    chk("both_count", 32'(got), 32'd4);
    repeat (8) @(negedge Clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
